// File: rtl/isa_pkg.sv
// Shared ISA definitions for the two-byte-instruction execution unit:
// opcode encoding, instruction field widths, FSM states and decode helpers.
package isa_pkg;

    localparam int OPC_BITS  = 4;
    localparam int RD_BITS   = 4;
    localparam int RS_BITS   = 4;
    localparam int IMM_BITS  = 8;
    localparam int BYTE_BITS = 8;

    typedef enum logic [OPC_BITS-1:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_JMP  = 4'd7,
        OP_JZ   = 4'd8,
        OP_HALT = 4'd9
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH_HI = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_HALTED   = 3'd3
    } state_e;

    // Opcodes that write rd and refresh the zero flag.
    function automatic logic op_writes_reg(input logic [OPC_BITS-1:0] op);
        logic w;
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w = 1'b1;
            default:                                       w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic op_is_illegal(input logic [OPC_BITS-1:0] op);
        return (op > OP_HALT);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_unit_param: LDI pass-through and the five
// two-operand operations, all modulo 2^DATA_BITS, plus a zero indication.
module exec_alu
    import isa_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic [OPC_BITS-1:0]  op_i,
    input  logic [DATA_BITS-1:0] a_i,
    input  logic [DATA_BITS-1:0] b_i,
    input  logic [IMM_BITS-1:0]  imm_i,
    output logic [DATA_BITS-1:0] result_o,
    output logic                 zero_o
);

    // Operation select; non-writing opcodes yield zero and are ignored upstream.
    always_comb begin
        result_o = {DATA_BITS{1'b0}};
        case (op_i)
            OP_LDI:  result_o = DATA_BITS'(imm_i);
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = {DATA_BITS{1'b0}};
        endcase
        zero_o = (result_o == {DATA_BITS{1'b0}});
    end

endmodule

// File: rtl/exec_unit_param.sv
// Multi-cycle execution unit: fetches two-byte instructions, executes on a
// small register file. Define EXEC_UNIT_STEP_EN to add single-step control.
module exec_unit_param
    import isa_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8,
    parameter int REG_COUNT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_BITS-1:0]         mem_addr,
    output logic                         mem_rd_req,
    input  logic [BYTE_BITS-1:0]         mem_rd_data,
    input  logic                         mem_rd_valid,
    output logic [ADDR_BITS-1:0]         pc,
    output logic                         halted,
    output logic                         illegal,
    input  logic [$clog2(REG_COUNT)-1:0] dbg_sel,
    output logic [DATA_BITS-1:0]         dbg_data
`ifdef EXEC_UNIT_STEP_EN
    ,
    input  logic                         step
`endif
);

    localparam int SEL_BITS = $clog2(REG_COUNT);

`ifdef EXEC_UNIT_STEP_EN
    localparam logic FREE_RUN = 1'b0;
`else
    localparam logic FREE_RUN = 1'b1;
`endif

    state_e                 state_q;
    logic [ADDR_BITS-1:0]   pc_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [BYTE_BITS-1:0]   ir_hi_q;
    logic [BYTE_BITS-1:0]   ir_lo_q;
    logic                   req_q;
    logic                   halted_q;
    logic                   illegal_q;
    logic                   z_q;
    logic [DATA_BITS-1:0]   regs_q [REG_COUNT];
`ifdef EXEC_UNIT_STEP_EN
    logic                   armed_q;
`endif

    logic [OPC_BITS-1:0]    opcode_s;
    logic [SEL_BITS-1:0]    rd_s;
    logic [SEL_BITS-1:0]    rs1_s;
    logic [SEL_BITS-1:0]    rs2_s;
    logic [ADDR_BITS-1:0]   imm_addr_s;
    logic [ADDR_BITS-1:0]   pc_seq_s;
    logic [ADDR_BITS-1:0]   pc_next_s;
    logic [DATA_BITS-1:0]   alu_result_s;
    logic                   alu_zero_s;
    logic                   writes_s;
    logic                   fetch_go_s;
    logic                   unused_rd_hi_s;

`ifdef EXEC_UNIT_STEP_EN
    assign fetch_go_s = armed_q;
`else
    assign fetch_go_s = 1'b1;
`endif

    // Upper rd bits are ignored when the register file is smaller than 16.
    assign unused_rd_hi_s = ^ir_hi_q[RD_BITS-1:0];

    // Field extraction and next-pc selection for the instruction in EXECUTE.
    always_comb begin
        opcode_s   = ir_hi_q[BYTE_BITS-1 -: OPC_BITS];
        rd_s       = ir_hi_q[SEL_BITS-1:0];
        rs1_s      = ir_lo_q[RS_BITS +: SEL_BITS];
        rs2_s      = ir_lo_q[0 +: SEL_BITS];
        imm_addr_s = ADDR_BITS'(ir_lo_q);
        pc_seq_s   = pc_q + ADDR_BITS'(2'd2);
        writes_s   = op_writes_reg(opcode_s);
        case (opcode_s)
            OP_JMP:  pc_next_s = imm_addr_s;
            OP_JZ: begin
                if (z_q) begin
                    pc_next_s = imm_addr_s;
                end else begin
                    pc_next_s = pc_seq_s;
                end
            end
            OP_HALT: pc_next_s = pc_q;
            default: pc_next_s = pc_seq_s;
        endcase
    end

    exec_alu #(
        .DATA_BITS (DATA_BITS)
    ) u_alu (
        .op_i     (opcode_s),
        .a_i      (regs_q[rs1_s]),
        .b_i      (regs_q[rs2_s]),
        .imm_i    (ir_lo_q),
        .result_o (alu_result_s),
        .zero_o   (alu_zero_s)
    );

    // Control FSM: two fetch beats, one execute beat; mem_addr/req are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH_HI;
            pc_q     <= {ADDR_BITS{1'b0}};
            addr_q   <= {ADDR_BITS{1'b0}};
            ir_hi_q  <= {BYTE_BITS{1'b0}};
            ir_lo_q  <= {BYTE_BITS{1'b0}};
            req_q    <= FREE_RUN;
            halted_q <= 1'b0;
`ifdef EXEC_UNIT_STEP_EN
            armed_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FETCH_HI: begin
                    if (fetch_go_s && mem_rd_valid) begin
                        ir_hi_q <= mem_rd_data;
                        addr_q  <= pc_q + ADDR_BITS'(1'b1);
                        state_q <= ST_FETCH_LO;
                    end
`ifdef EXEC_UNIT_STEP_EN
                    else if (!armed_q && step) begin
                        armed_q <= 1'b1;
                        req_q   <= 1'b1;
                    end
`endif
                end
                ST_FETCH_LO: begin
                    if (mem_rd_valid) begin
                        ir_lo_q <= mem_rd_data;
                        req_q   <= 1'b0;
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    pc_q   <= pc_next_s;
                    addr_q <= pc_next_s;
`ifdef EXEC_UNIT_STEP_EN
                    armed_q <= 1'b0;
`endif
                    if (opcode_s == OP_HALT) begin
                        halted_q <= 1'b1;
                        req_q    <= 1'b0;
                        state_q  <= ST_HALTED;
                    end else begin
                        req_q    <= FREE_RUN;
                        state_q  <= ST_FETCH_HI;
                    end
                end
                ST_HALTED: begin
                    req_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_FETCH_HI;
                end
            endcase
        end
    end

    // Register file, zero flag and sticky illegal flag; updated only in EXECUTE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= {DATA_BITS{1'b0}};
            end
            z_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state_q == ST_EXECUTE) begin
            if (writes_s) begin
                regs_q[rd_s] <= alu_result_s;
                z_q          <= alu_zero_s;
            end
            if (op_is_illegal(opcode_s)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Request is forced low while reset is high so an in-flight fetch is dropped.
    assign mem_rd_req = req_q & ~reset;
    assign mem_addr   = addr_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_exec_unit_param.sv
// Directed self-checking bench for exec_unit_param (default 8/8/4 instance
// plus an ADDR_BITS=4 instance for pc wrap-around).
module tb_exec_unit_param;

    logic       clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_rd_req;
    logic [7:0] mem_rd_data;
    logic       mem_rd_valid;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    logic [3:0] mem_addr4;
    logic       mem_rd_req4;
    logic [7:0] mem_rd_data4;
    logic       mem_rd_valid4;
    logic [3:0] pc4;
    logic       halted4;
    logic       illegal4;
    logic [1:0] dbg_sel4;
    logic [7:0] dbg_data4;
`ifdef EXEC_UNIT_STEP_EN
    logic       step = 1'b1;
`endif

    logic [7:0] mem [256];
    int         wait_cycles;
    int         cnt;
    int         stab_err;
    logic       prev_req;
    logic       prev_valid;
    logic [7:0] prev_addr;
    int         total;
    int         bad;

    exec_unit_param #(.DATA_BITS(8), .ADDR_BITS(8), .REG_COUNT(4)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .pc(pc),
        .halted(halted), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef EXEC_UNIT_STEP_EN
        , .step(step)
`endif
    );

    exec_unit_param #(.DATA_BITS(8), .ADDR_BITS(4), .REG_COUNT(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr4), .mem_rd_req(mem_rd_req4),
        .mem_rd_data(mem_rd_data4), .mem_rd_valid(mem_rd_valid4), .pc(pc4),
        .halted(halted4), .illegal(illegal4), .dbg_sel(dbg_sel4), .dbg_data(dbg_data4)
`ifdef EXEC_UNIT_STEP_EN
        , .step(step)
`endif
    );

    // Memory responder: grants each fetch after wait_cycles idle cycles and
    // counts any address change or request drop before the grant.
    always @(negedge clk) begin
        if (reset || !mem_rd_req) begin
            cnt          = 0;
            mem_rd_valid = 1'b0;
        end else begin
            if (prev_req && !prev_valid && mem_addr != prev_addr) stab_err++;
            if (!prev_req || prev_valid) cnt = 0;
            else cnt++;
            mem_rd_valid = (cnt >= wait_cycles);
        end
        if (prev_req && !prev_valid && !mem_rd_req && !reset) stab_err++;
        mem_rd_data = mem[mem_addr];
        prev_req    = mem_rd_req && !reset;
        prev_valid  = mem_rd_valid;
        prev_addr   = mem_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load_prog_a;
        clear_mem;
        mem[0] = 8'h11; mem[1] = 8'h05;
        mem[2] = 8'h12; mem[3] = 8'h03;
        mem[4] = 8'h20; mem[5] = 8'h12;
        mem[6] = 8'h90; mem[7] = 8'h00;
    endtask

    task automatic run_to_halt(input int budget, output bit done, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            tick;
            cycles++;
        end
        done = halted;
    endtask

    task automatic read_reg(input int idx, output logic [7:0] v);
        dbg_sel = idx[1:0];
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b1;
        tick;
        tick;
        total++; if (mem_rd_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", mem_rd_req); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", halted, illegal); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_r%0d got=%0h exp=0", i, v); end
        end
        reset = 1'b0;
        #1;
        total++; if (mem_rd_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL reset_first_fetch got req=%0b addr=%0h exp req=1 addr=0", mem_rd_req, mem_addr); end
    endtask

    task automatic test_basic_program;
        logic [7:0] v;
        logic [7:0] exp_r [4];
        exp_r = '{8'h08, 8'h05, 8'h03, 8'h00};
        load_prog_a;
        wait_cycles = 0;
        do_reset;
        repeat (11) tick;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL basic_early_halt got=%0b exp=0", halted); end
        tick;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL basic_halted got=%0b exp=1", halted); end
        total++; if (pc !== 8'h06) begin bad++; $display("FAIL basic_pc got=%0h exp=6", pc); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            total++; if (v !== exp_r[i]) begin bad++; $display("FAIL basic_r%0d got=%0h exp=%0h", i, v, exp_r[i]); end
        end
        repeat (3) tick;
        total++; if (pc !== 8'h06 || mem_rd_req !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL basic_hold got pc=%0h req=%0b halted=%0b exp pc=6 req=0 halted=1", pc, mem_rd_req, halted); end
    endtask

    task automatic test_alu_ops;
        logic [7:0] v;
        logic [7:0] exp_r [4];
        bit done;
        int cyc;
        exp_r = '{8'hFE, 8'h0E, 8'h00, 8'h08};
        clear_mem;
        mem[0]  = 8'h11; mem[1]  = 8'h0C;
        mem[2]  = 8'h12; mem[3]  = 8'h0A;
        mem[4]  = 8'h30; mem[5]  = 8'h21;
        mem[6]  = 8'h43; mem[7]  = 8'h12;
        mem[8]  = 8'h80; mem[9]  = 8'h40;
        mem[10] = 8'h51; mem[11] = 8'h12;
        mem[12] = 8'h62; mem[13] = 8'h11;
        mem[14] = 8'h70; mem[15] = 8'h30;
        mem[8'h30] = 8'h90;
        mem[8'h40] = 8'h90;
        do_reset;
        run_to_halt(200, done, cyc);
        total++; if (!done || pc !== 8'h30) begin bad++; $display("FAIL alu_pc got=%0h done=%0b exp=30", pc, done); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            total++; if (v !== exp_r[i]) begin bad++; $display("FAIL alu_r%0d got=%0h exp=%0h", i, v, exp_r[i]); end
        end
    endtask

    task automatic test_zero_flag_jz;
        logic [7:0] v;
        bit done;
        int cyc;
        clear_mem;
        mem[0] = 8'h11; mem[1] = 8'hFF;
        mem[2] = 8'h12; mem[3] = 8'h01;
        mem[4] = 8'h23; mem[5] = 8'h12;
        mem[6] = 8'h80; mem[7] = 8'h20;
        mem[8] = 8'h90;
        mem[8'h20] = 8'h90;
        do_reset;
        run_to_halt(200, done, cyc);
        total++; if (!done || pc !== 8'h20) begin bad++; $display("FAIL jz_pc got=%0h done=%0b exp=20", pc, done); end
        read_reg(3, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL wrap_r3 got=%0h exp=0", v); end
        read_reg(1, v);
        total++; if (v !== 8'hFF) begin bad++; $display("FAIL wrap_r1 got=%0h exp=ff", v); end
    endtask

    task automatic test_wait_states;
        logic [7:0] v;
        logic [7:0] exp_r [4];
        bit done;
        int cyc;
        exp_r = '{8'h08, 8'h05, 8'h03, 8'h00};
        load_prog_a;
        wait_cycles = 3;
        stab_err = 0;
        do_reset;
        run_to_halt(200, done, cyc);
        total++; if (!done || cyc != 36) begin bad++; $display("FAIL wait_cycles got=%0d done=%0b exp=36", cyc, done); end
        total++; if (pc !== 8'h06) begin bad++; $display("FAIL wait_pc got=%0h exp=6", pc); end
        total++; if (stab_err != 0) begin bad++; $display("FAIL wait_stable got=%0d exp=0", stab_err); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            total++; if (v !== exp_r[i]) begin bad++; $display("FAIL wait_r%0d got=%0h exp=%0h", i, v, exp_r[i]); end
        end
        wait_cycles = 0;
    endtask

    task automatic test_illegal;
        logic [7:0] v;
        bit done;
        int cyc;
        clear_mem;
        mem[0] = 8'hC3; mem[1] = 8'h55;
        mem[2] = 8'h15; mem[3] = 8'h77;
        mem[4] = 8'h90;
        do_reset;
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_init got=%0b exp=0", illegal); end
        repeat (3) tick;
        total++; if (illegal !== 1'b1 || pc !== 8'h02) begin bad++; $display("FAIL ill_exec got ill=%0b pc=%0h exp ill=1 pc=2", illegal, pc); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL ill_r%0d got=%0h exp=0", i, v); end
        end
        run_to_halt(100, done, cyc);
        read_reg(1, v);
        total++; if (!done || illegal !== 1'b1 || v !== 8'h77 || pc !== 8'h04) begin bad++; $display("FAIL ill_sticky got ill=%0b r1=%0h pc=%0h exp ill=1 r1=77 pc=4", illegal, v, pc); end
    endtask

    task automatic test_addr_wrap;
        do_reset;
        repeat (21) tick;
        total++; if (pc4 !== 4'd14) begin bad++; $display("FAIL wrap_pc14 got=%0d exp=14", pc4); end
        tick;
        total++; if (mem_addr4 !== 4'd15) begin bad++; $display("FAIL wrap_addr15 got=%0d exp=15", mem_addr4); end
        repeat (2) tick;
        total++; if (pc4 !== 4'd0 || halted4 !== 1'b0) begin bad++; $display("FAIL wrap_pc0 got=%0d exp=0", pc4); end
    endtask

    task automatic test_reset_mid_fetch;
        logic [7:0] v;
        bit found;
        bit done;
        int cyc;
        load_prog_a;
        wait_cycles = 3;
        stab_err = 0;
        do_reset;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick;
            found = (mem_rd_req === 1'b1 && mem_addr === 8'h03);
        end
        total++; if (!found) begin bad++; $display("FAIL mid_reach got=0 exp=1"); end
        read_reg(1, v);
        total++; if (v !== 8'h05) begin bad++; $display("FAIL mid_pre_r1 got=%0h exp=5", v); end
        tick;
        reset = 1'b1;
        #1;
        total++; if (mem_rd_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop got=%0b exp=0", mem_rd_req); end
        tick;
        read_reg(1, v);
        total++; if (pc !== 8'h00 || v !== 8'h00) begin bad++; $display("FAIL mid_clear got pc=%0h r1=%0h exp pc=0 r1=0", pc, v); end
        reset = 1'b0;
        #1;
        total++; if (mem_rd_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL mid_restart got req=%0b addr=%0h exp req=1 addr=0", mem_rd_req, mem_addr); end
        run_to_halt(200, done, cyc);
        read_reg(0, v);
        total++; if (!done || v !== 8'h08 || pc !== 8'h06 || stab_err != 0) begin bad++; $display("FAIL mid_rerun got r0=%0h pc=%0h stab=%0d exp r0=8 pc=6 stab=0", v, pc, stab_err); end
        wait_cycles = 0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        wait_cycles   = 0;
        cnt           = 0;
        stab_err      = 0;
        prev_req      = 1'b0;
        prev_valid    = 1'b0;
        prev_addr     = 8'h00;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = 8'h00;
        mem_rd_valid4 = 1'b1;
        mem_rd_data4  = 8'h00;
        dbg_sel       = 2'd0;
        dbg_sel4      = 2'd0;
        reset         = 1'b1;
        clear_mem;
        test_reset;
        test_basic_program;
        test_alu_ops;
        test_zero_flag_jz;
        test_wait_states;
        test_illegal;
        test_addr_wrap;
        test_reset_mid_fetch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
